// File: rtl/branch_seq_ctrl_if.sv
// branch_seq_ctrl_if: D-stage operands/flags in, fetch PC and control status out.
interface branch_seq_ctrl_if;
    logic [31:0] instr_D;
    logic [31:0] pc4_D;
    logic [31:0] imm_ext_D;
    logic [31:0] rs_val_D;
    logic        equal;
    logic        greater;
    logic        g_or_e;
    logic        opnd_ready;
    logic        stall_ext;
    logic        exc_req;
    logic [31:0] pc_F;
    logic        stall_FD;
    logic        br_taken;
    logic        wait_err;
    logic [31:0] stat_br;
    logic [31:0] stat_taken;
    logic [31:0] stat_stall;
    modport master (
        output instr_D, pc4_D, imm_ext_D, rs_val_D, equal, greater, g_or_e,
               opnd_ready, stall_ext, exc_req,
        input  pc_F, stall_FD, br_taken, wait_err, stat_br, stat_taken, stat_stall
    );
    modport slave (
        input  instr_D, pc4_D, imm_ext_D, rs_val_D, equal, greater, g_or_e,
               opnd_ready, stall_ext, exc_req,
        output pc_F, stall_FD, br_taken, wait_err, stat_br, stat_taken, stat_stall
    );
endinterface

// File: rtl/branch_seq_ctrl.sv
// branch_seq_ctrl: D-stage branch/jump resolver owning the fetch PC, with operand-wait stall FSM.
// Optional statistics counters built only when BR_STATS_EN is defined.
module branch_seq_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000,
    parameter logic [31:0] EXC_PC   = 32'h0000_4180,
    parameter logic [7:0]  MAX_WAIT = 8'd8
) (
    input  logic              clk,
    input  logic              reset,
    branch_seq_ctrl_if.slave  bus
);
    typedef enum logic {RUN, WAIT} state_t;
    state_t      state_q, state_d;
    logic [7:0]  wait_cnt_q, wait_cnt_d;
    logic        wait_err_q, wait_err_d;
    logic [31:0] pc_q, pc_d;
    logic [5:0]  op, fn;
    logic [4:0]  rt;
    logic        is_cond, cond_ok, is_jump, stall_fd, taken, resolve;
    logic [31:0] target;
    assign op = bus.instr_D[31:26];
    assign rt = bus.instr_D[20:16];
    assign fn = bus.instr_D[5:0];
    always_comb begin
        is_cond = 1'b0;
        cond_ok = 1'b0;
        is_jump = 1'b0;
        target  = bus.pc4_D + (bus.imm_ext_D << 2);
        case (op)
            6'b000100: begin is_cond = 1'b1; cond_ok = bus.equal; end
            6'b000101: begin is_cond = 1'b1; cond_ok = !bus.equal; end
            6'b000110: begin is_cond = 1'b1; cond_ok = !bus.greater; end
            6'b000111: begin is_cond = 1'b1; cond_ok = bus.greater; end
            6'b000001: begin
                is_cond = (rt == 5'd0) || (rt == 5'd1);
                cond_ok = rt[0] ? bus.g_or_e : !bus.g_or_e;
            end
            6'b000010, 6'b000011: begin
                is_jump = 1'b1;
                target  = {bus.pc4_D[31:28], bus.instr_D[25:0], 2'b00};
            end
            6'b000000: begin
                is_jump = (fn == 6'b001000) || (fn == 6'b001001);
                target  = bus.rs_val_D;
            end
            default: ;
        endcase
    end
    // Exception wins over everything; stall_ext freezes the FSM but not the stall indication.
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        wait_err_d = wait_err_q;
        stall_fd   = 1'b0;
        taken      = 1'b0;
        if (bus.exc_req) begin
            state_d    = RUN;
            wait_cnt_d = 8'd0;
        end else begin
            stall_fd = (state_q == WAIT) ? !bus.opnd_ready : (is_cond || is_jump) && !bus.opnd_ready;
            taken    = !stall_fd && !bus.stall_ext && (is_jump || (is_cond && cond_ok));
            if (!bus.stall_ext) begin
                state_d    = stall_fd ? WAIT : RUN;
                wait_cnt_d = !stall_fd ? 8'd0 : (state_q == RUN) ? 8'd1 :
                             (wait_cnt_q == 8'hFF) ? wait_cnt_q : wait_cnt_q + 8'd1;
                wait_err_d = wait_err_q || (stall_fd && wait_cnt_d == MAX_WAIT);
            end
        end
        pc_d = bus.exc_req ? EXC_PC : (stall_fd || bus.stall_ext) ? pc_q :
               taken ? target : pc_q + 32'd4;
    end
    assign resolve = !bus.exc_req && !stall_fd && !bus.stall_ext && is_cond;
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= RUN;
            wait_cnt_q <= 8'd0;
            wait_err_q <= 1'b0;
            pc_q       <= RESET_PC;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            wait_err_q <= wait_err_d;
            pc_q       <= pc_d;
        end
    end
    assign bus.pc_F     = pc_q;
    assign bus.stall_FD = stall_fd;
    assign bus.br_taken = taken;
    assign bus.wait_err = wait_err_q;
`ifdef BR_STATS_EN
    logic [31:0] stat_br_q, stat_taken_q, stat_stall_q;
    always_ff @(posedge clk) begin
        if (reset) begin
            stat_br_q    <= 32'd0;
            stat_taken_q <= 32'd0;
            stat_stall_q <= 32'd0;
        end else begin
            stat_br_q    <= stat_br_q + {31'd0, resolve};
            stat_taken_q <= stat_taken_q + {31'd0, resolve && cond_ok};
            stat_stall_q <= stat_stall_q + {31'd0, stall_fd};
        end
    end
    assign bus.stat_br    = stat_br_q;
    assign bus.stat_taken = stat_taken_q;
    assign bus.stat_stall = stat_stall_q;
`else
    logic unused_resolve;
    assign unused_resolve = resolve;
    assign bus.stat_br    = 32'd0;
    assign bus.stat_taken = 32'd0;
    assign bus.stat_stall = 32'd0;
`endif
endmodule
